// File: rtl/cpu_trace_buffer_if.sv
// Trace drain stream: head-of-FIFO (pc, instruction) entry with valid/ready handshake.
interface cpu_trace_buffer_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_ins;

    modport master (output out_valid, output out_pc, output out_ins, input  out_ready);
    modport slave  (input  out_valid, input  out_pc, input  out_ins, output out_ready);
endinterface

// File: rtl/cpu_trace_buffer.sv
// PC-change trace recorder: captures (pc, ins) on each PC change into a FWFT FIFO
// drained over valid/ready, with sticky overflow flag and saturating drop counter.
module cpu_trace_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DROP_W = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [31:0]         now_pc,
    input  logic [31:0]         ins,
    input  logic                trace_en,
    input  logic                clear,
    cpu_trace_buffer_if.master  trace,
    output logic [ADDR_W:0]     count,
    output logic                full,
    output logic                overflow,
    output logic [DROP_W-1:0]   drop_cnt
);
    localparam logic [ADDR_W:0]   FULL_CNT = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
    localparam logic [DROP_W-1:0] DROP_ONE = 1;

    logic              r_first;
    logic [31:0]       r_last_pc;
    logic              r_stg_valid;
    logic [31:0]       r_stg_pc;
    logic [31:0]       r_mem_pc  [DEPTH];
    logic [31:0]       r_mem_ins [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic [DROP_W-1:0] r_drop_cnt;

    logic w_det;
    logic w_full;
    logic w_pop;
    logic w_push_ok;
    logic w_drop;

    assign w_det     = trace_en && (r_first || (now_pc != r_last_pc));
    assign w_full    = (r_count == FULL_CNT);
    assign w_pop     = trace.out_valid && trace.out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push_ok = r_stg_valid && (!w_full || w_pop);
    assign w_drop    = r_stg_valid && w_full && !w_pop;

    assign trace.out_valid = (r_count != '0);
    assign trace.out_pc    = r_mem_pc[r_rd_ptr];
    assign trace.out_ins   = r_mem_ins[r_rd_ptr];
    assign count           = r_count;
    assign full            = w_full;
    assign overflow        = r_overflow;
    assign drop_cnt        = r_drop_cnt;

    // Stage the PC one cycle so the instruction register has loaded before the push.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_first     <= 1'b1;
            r_last_pc   <= '0;
            r_stg_valid <= 1'b0;
            r_stg_pc    <= '0;
        end else if (clear) begin
            r_first     <= 1'b1;
            r_stg_valid <= 1'b0;
        end else begin
            r_stg_valid <= w_det;
            if (w_det)
                r_stg_pc <= now_pc;
            if (trace_en) begin
                r_last_pc <= now_pc;
                r_first   <= 1'b0;
            end else begin
                r_first   <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_pc[i]  <= '0;
                r_mem_ins[i] <= '0;
            end
        end else if (!clear && w_push_ok) begin
            r_mem_pc[r_wr_ptr]  <= r_stg_pc;
            r_mem_ins[r_wr_ptr] <= ins;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != '1)
                    r_drop_cnt <= r_drop_cnt + DROP_ONE;
            end
        end
    end
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer: vector table for the basic capture
// sequences, scoreboard of expected entries checked at every pop.
module tb_cpu_trace_buffer;
    logic        CLK;
    logic        RST;
    logic [31:0] now_pc;
    logic [31:0] ins;
    logic        trace_en;
    logic        clear;
    logic [4:0]  count;
    logic        full;
    logic        overflow;
    logic [7:0]  drop_cnt;

    cpu_trace_buffer_if trc ();

    cpu_trace_buffer #(.DEPTH(16), .ADDR_W(4), .DROP_W(8)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .now_pc   (now_pc),
        .ins      (ins),
        .trace_en (trace_en),
        .clear    (clear),
        .trace    (trc.master),
        .count    (count),
        .full     (full),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    typedef struct {
        logic        en;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        rdy;
        logic        push;
        logic [4:0]  cnt;
        logic        vld;
    } vec_t;

    localparam logic [31:0] I0 = 32'h0800_0004;
    localparam logic [31:0] I4 = 32'h00a0_0093;
    localparam logic [31:0] I8 = 32'h0010_0113;

    ent_t sb[$];
    vec_t tbl[15];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] g(input logic [31:0] pc);
        return pc ^ 32'hDEAD_0013;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: check any pop at the negedge against the scoreboard, settle past the posedge.
    task automatic step();
        ent_t e;
        @(negedge CLK);
        if (RST && !clear && trc.out_valid && trc.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got pc %0h, no entry expected", trc.out_pc);
            end else begin
                e = sb.pop_front();
                chk("pop_pc", {32'h0, trc.out_pc}, {32'h0, e.pc});
                chk("pop_ins", {32'h0, trc.out_ins}, {32'h0, e.ins});
            end
        end
        @(posedge CLK);
        #1;
    endtask

    // n distinct PCs one per cycle (ins follows PC), last one held one extra cycle.
    task automatic burst(input logic [31:0] base, input int n, input int keep);
        ent_t e;
        for (int i = 0; i < n; i++) begin
            now_pc   = base + 32'(4 * i);
            ins      = g(now_pc);
            trace_en = 1'b1;
            if (i < keep) begin
                e.pc  = now_pc;
                e.ins = (i < n - 1) ? g(base + 32'(4 * (i + 1))) : g(now_pc);
                sb.push_back(e);
            end
            step();
        end
        step();
    endtask

    task automatic drain(input int bound);
        trc.out_ready = 1'b1;
        for (int i = 0; i < bound && count != 0; i++)
            step();
        chk("drain_count", {59'h0, count}, 64'd0);
        chk("drain_valid", {63'h0, trc.out_valid}, 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        trc.out_ready = 1'b0;
    endtask

    task automatic do_clear();
        trace_en      = 1'b0;
        trc.out_ready = 1'b0;
        clear         = 1'b1;
        step();
        clear = 1'b0;
        sb.delete();
    endtask

    initial begin
        ent_t e;
        tbl[0]  = '{1'b1, 32'h0, I0, 1'b0, 1'b0, 5'd0, 1'b0};
        tbl[1]  = '{1'b1, 32'h0, I0, 1'b0, 1'b1, 5'd1, 1'b1};
        tbl[2]  = '{1'b1, 32'h0, I0, 1'b0, 1'b0, 5'd1, 1'b1};
        tbl[3]  = '{1'b1, 32'h0, I0, 1'b1, 1'b0, 5'd0, 1'b0};
        tbl[4]  = '{1'b1, 32'h0, I0, 1'b1, 1'b0, 5'd0, 1'b0};
        tbl[5]  = '{1'b0, 32'h0, I0, 1'b1, 1'b0, 5'd0, 1'b0};
        tbl[6]  = '{1'b1, 32'h0, I0, 1'b1, 1'b0, 5'd0, 1'b0};
        tbl[7]  = '{1'b1, 32'h0, I0, 1'b1, 1'b1, 5'd1, 1'b1};
        tbl[8]  = '{1'b1, 32'h0, I0, 1'b1, 1'b0, 5'd0, 1'b0};
        tbl[9]  = '{1'b1, 32'h4, I0, 1'b1, 1'b0, 5'd0, 1'b0};
        tbl[10] = '{1'b1, 32'h4, I4, 1'b1, 1'b1, 5'd1, 1'b1};
        tbl[11] = '{1'b1, 32'h4, I4, 1'b1, 1'b0, 5'd0, 1'b0};
        tbl[12] = '{1'b1, 32'h8, I4, 1'b1, 1'b0, 5'd0, 1'b0};
        tbl[13] = '{1'b1, 32'h8, I8, 1'b1, 1'b1, 5'd1, 1'b1};
        tbl[14] = '{1'b1, 32'h8, I8, 1'b1, 1'b0, 5'd0, 1'b0};

        RST = 1'b0; now_pc = '0; ins = '0; trace_en = 1'b0; clear = 1'b0; trc.out_ready = 1'b0;
        #12;
        chk("rst_count", {59'h0, count}, 64'd0);
        chk("rst_valid", {63'h0, trc.out_valid}, 64'd0);
        chk("rst_full", {63'h0, full}, 64'd0);
        chk("rst_overflow", {63'h0, overflow}, 64'd0);
        chk("rst_drop", {56'h0, drop_cnt}, 64'd0);
        chk("rst_out_pc", {32'h0, trc.out_pc}, 64'd0);
        chk("rst_out_ins", {32'h0, trc.out_ins}, 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        step();

        // Stable-PC single capture, then the 0x0/0x4/0x8 sequence with ready high.
        for (int i = 0; i < 15; i++) begin
            trace_en      = tbl[i].en;
            now_pc        = tbl[i].pc;
            ins           = tbl[i].ins;
            trc.out_ready = tbl[i].rdy;
            if (tbl[i].push) begin
                e.pc  = tbl[i].pc;
                e.ins = tbl[i].ins;
                sb.push_back(e);
            end
            step();
            chk($sformatf("vec%0d_count", i), {59'h0, count}, {59'h0, tbl[i].cnt});
            chk($sformatf("vec%0d_valid", i), {63'h0, trc.out_valid}, {63'h0, tbl[i].vld});
        end
        trc.out_ready = 1'b0;
        chk("seq_sb_empty", 64'(sb.size()), 64'd0);

        // 20 distinct PCs into a stalled consumer: 16 kept, 4 dropped.
        burst(32'h1000, 20, 16);
        chk("ovf_count", {59'h0, count}, 64'd16);
        chk("ovf_full", {63'h0, full}, 64'd1);
        chk("ovf_flag", {63'h0, overflow}, 64'd1);
        chk("ovf_drop", {56'h0, drop_cnt}, 64'd4);
        drain(40);

        // Full FIFO, push and pop in the same cycle.
        burst(32'h2000, 16, 16);
        chk("fill_count", {59'h0, count}, 64'd16);
        now_pc = 32'h3000; ins = g(32'h3000);
        step();
        trc.out_ready = 1'b1;
        e.pc = 32'h3000; e.ins = g(32'h3000);
        sb.push_back(e);
        step();
        trc.out_ready = 1'b0;
        step();
        chk("pp_count", {59'h0, count}, 64'd16);
        chk("pp_full", {63'h0, full}, 64'd1);
        chk("pp_drop", {56'h0, drop_cnt}, 64'd4);
        drain(40);

        // Drop counter saturation, then clear.
        do_clear();
        chk("clr0_drop", {56'h0, drop_cnt}, 64'd0);
        chk("clr0_overflow", {63'h0, overflow}, 64'd0);
        burst(32'h4000, 316, 16);
        chk("sat_drop", {56'h0, drop_cnt}, 64'd255);
        chk("sat_overflow", {63'h0, overflow}, 64'd1);
        chk("sat_count", {59'h0, count}, 64'd16);
        do_clear();
        chk("clr_count", {59'h0, count}, 64'd0);
        chk("clr_overflow", {63'h0, overflow}, 64'd0);
        chk("clr_drop", {56'h0, drop_cnt}, 64'd0);
        chk("clr_valid", {63'h0, trc.out_valid}, 64'd0);
        chk("clr_full", {63'h0, full}, 64'd0);

        // Asynchronous reset with a staged capture pending.
        trace_en = 1'b1; now_pc = 32'h5000; ins = g(32'h5000);
        step();
        now_pc = 32'h5004; ins = g(32'h5004);
        step();
        chk("pre_rst_count", {59'h0, count}, 64'd1);
        chk("pre_rst_pc", {32'h0, trc.out_pc}, {32'h0, 32'h5000});
        #2;
        RST = 1'b0;
        #1;
        chk("arst_count", {59'h0, count}, 64'd0);
        chk("arst_valid", {63'h0, trc.out_valid}, 64'd0);
        chk("arst_full", {63'h0, full}, 64'd0);
        chk("arst_overflow", {63'h0, overflow}, 64'd0);
        chk("arst_drop", {56'h0, drop_cnt}, 64'd0);
        chk("arst_out_pc", {32'h0, trc.out_pc}, 64'd0);
        chk("arst_out_ins", {32'h0, trc.out_ins}, 64'd0);
        sb.delete();
        trace_en = 1'b0;
        trc.out_ready = 1'b1;
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_count", {59'h0, count}, 64'd0);
            chk("post_rst_valid", {63'h0, trc.out_valid}, 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
